clk_gen_step: RTL

Parametrised successor to the board clock divider. Free-running divide counter plus a registered, glitch-free CPU clock with four modes: fast tap, slow tap, debounced single-step, and hold. Also emits a one-cycle tick per CPU clock rising edge and a CPU cycle counter. Sits between the board oscillator/buttons and the multi-cycle CPU and display logic.

---
 rtl/clk_gen_step.sv | 122 ++++++++++++
 1 files changed

// File: rtl/clk_gen_step.sv
// Board clock generator for the multi-cycle CPU.
// A free-running divide counter feeds a registered, glitch-free CPU clock.
// The CPU clock has four modes: fast tap, slow tap, debounced single-step and hold.
// It also produces a rising-edge tick and a count of CPU clock cycles.
module clk_gen_step #(
    parameter int WIDTH     = 32,
    parameter int FAST_BIT  = 1,
    parameter int SLOW_BIT  = 24,
    parameter int DB_CYCLES = 1000000,
    parameter int STEP_HI   = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    output logic [WIDTH-1:0] clkdiv,
    output logic             Clk_CPU,
    output logic             cpu_tick,
    output logic [CNT_W-1:0] cpu_cycles,
    output logic [1:0]       mode_act
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int SW   = $clog2(STEP_HI + 1);

    typedef enum logic [1:0] {
        MODE_FAST = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_STEP = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    logic [WIDTH-1:0] clkdiv_q, clkdiv_d;
    logic             clkCpu_q, clkCpu_d;
    logic             clkCpuPrev_q;
    logic [CNT_W-1:0] cpuCycles_q, cpuCycles_d;
    mode_e            modeAct_q, modeAct_d;
    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [DB_W-1:0]  dbCnt_q, dbCnt_d;
    logic [SW-1:0]    stepCnt_q, stepCnt_d;
    logic             dbRise;

    // Next-state logic: divider, deferred mode load, debounce, step pulse and CPU clock select
    always_comb begin
        clkdiv_d    = clkdiv_q + WIDTH'(1);
        modeAct_d   = modeAct_q;
        db_d        = db_q;
        dbCnt_d     = dbCnt_q;
        dbRise      = 1'b0;
        stepCnt_d   = stepCnt_q;
        clkCpu_d    = 1'b0;
        cpuCycles_d = cpuCycles_q;

        if (!clkCpu_q) begin
            modeAct_d = mode_e'(mode);
        end

        if (sync2_q == db_q) begin
            dbCnt_d = '0;
        end else if (dbCnt_q == DB_W'(DB_CYCLES - 1)) begin
            db_d    = sync2_q;
            dbCnt_d = '0;
            dbRise  = sync2_q;
        end else begin
            dbCnt_d = dbCnt_q + DB_W'(1);
        end

        if (stepCnt_q != '0) begin
            stepCnt_d = stepCnt_q - SW'(1);
        end else if (dbRise && (modeAct_q == MODE_STEP)) begin
            stepCnt_d = SW'(STEP_HI);
        end

        case (modeAct_q)
            MODE_FAST: clkCpu_d = clkdiv_q[FAST_BIT];
            MODE_SLOW: clkCpu_d = clkdiv_q[SLOW_BIT];
            MODE_STEP: clkCpu_d = (stepCnt_q != '0);
            MODE_HOLD: clkCpu_d = 1'b0;
            default:   clkCpu_d = 1'b0;
        endcase

        if (clkCpu_d && !clkCpu_q) begin
            cpuCycles_d = cpuCycles_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; reset also aborts any step pulse in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            clkdiv_q     <= '0;
            clkCpu_q     <= 1'b0;
            clkCpuPrev_q <= 1'b0;
            cpuCycles_q  <= '0;
            modeAct_q    <= MODE_FAST;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_q         <= 1'b0;
            dbCnt_q      <= '0;
            stepCnt_q    <= '0;
        end else begin
            clkdiv_q     <= clkdiv_d;
            clkCpu_q     <= clkCpu_d;
            clkCpuPrev_q <= clkCpu_q;
            cpuCycles_q  <= cpuCycles_d;
            modeAct_q    <= modeAct_d;
            sync1_q      <= step_btn;
            sync2_q      <= sync1_q;
            db_q         <= db_d;
            dbCnt_q      <= dbCnt_d;
            stepCnt_q    <= stepCnt_d;
        end
    end

    assign clkdiv     = clkdiv_q;
    assign Clk_CPU    = clkCpu_q;
    assign cpu_tick   = clkCpu_q & ~clkCpuPrev_q;
    assign cpu_cycles = cpuCycles_q;
    assign mode_act   = modeAct_q;

endmodule
